// File: rtl/spi_byte_shifter.sv
// spi_byte_shifter: full-duplex SPI mode-0 byte engine fed by a
// clock_divider (sclk is edge-detected in i_clk, never used as a clock).
// Ports: i_clk, i_rst_n (sync, active-low)
//   request: i_data, i_start_n, o_ready
//   result:  o_data, o_valid, o_err
//   divider: o_div_start_n, i_div_ready, i_sclk
//   spi:     i_miso, o_mosi, o_cs_n
module spi_byte_shifter #(
  parameter bit MSB_FIRST   = 1'b1,
  parameter int ARM_TIMEOUT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_start_n,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_div_start_n,
  input  logic       i_div_ready,
  input  logic       i_sclk,
  input  logic       i_miso,
  output logic       o_mosi,
  output logic       o_cs_n
);

  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [AW-1:0] ARM_LAST =
    AW'(ARM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    SHIFT
  } state_t;

  state_t        state, state_d;
  logic [7:0]    tx, tx_d;
  logic [7:0]    rx, rx_d;
  logic [7:0]    data_d;
  logic [3:0]    bit_cnt, bit_d;
  logic [AW-1:0] arm_cnt, arm_d;
  logic          sclk_q;
  logic          rise, fall;
  logic          ready_d, valid_d, err_d;
  logic          dstart_d, mosi_d, cs_d;

  function automatic logic head(
    input logic [7:0] b
  );
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  function automatic logic [7:0] adv(
    input logic [7:0] b
  );
    return MSB_FIRST ? {b[6:0], 1'b0}
                     : {1'b0, b[7:1]};
  endfunction

  function automatic logic [7:0] push(
    input logic [7:0] b,
    input logic       d
  );
    return MSB_FIRST ? {b[6:0], d}
                     : {d, b[7:1]};
  endfunction

  assign rise = i_sclk & ~sclk_q;
  assign fall = ~i_sclk & sclk_q;

  always_comb begin
    state_d  = state;
    tx_d     = tx;
    rx_d     = rx;
    bit_d    = bit_cnt;
    arm_d    = arm_cnt;
    data_d   = o_data;
    ready_d  = o_ready;
    cs_d     = o_cs_n;
    dstart_d = o_div_start_n;
    mosi_d   = o_mosi;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!i_start_n) begin
          tx_d     = i_data;
          rx_d     = 8'h00;
          bit_d    = 4'd0;
          arm_d    = '0;
          ready_d  = 1'b0;
          cs_d     = 1'b0;
          dstart_d = 1'b0;
          mosi_d   = head(i_data);
          state_d  = ARM;
        end
      end
      ARM: begin
        if (!i_div_ready) begin
          dstart_d = 1'b1;
          state_d  = SHIFT;
        end else if (arm_cnt == ARM_LAST) begin
          err_d    = 1'b1;
          cs_d     = 1'b1;
          dstart_d = 1'b1;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else begin
          arm_d = arm_cnt + AW'(1);
        end
      end
      SHIFT: begin
        unique case (1'b1)
          rise: begin
            rx_d = push(rx, i_miso);
            if (bit_cnt != 4'hF)
              bit_d = bit_cnt + 4'd1;
          end
          fall: begin
            // the eighth fall has nothing left to send
            if (bit_cnt < 4'd8) begin
              tx_d   = adv(tx);
              mosi_d = head(tx_d);
            end
          end
          default: ;
        endcase
        // a same-cycle rise is already folded into rx_d/bit_d
        if (i_div_ready) begin
          data_d  = rx_d;
          valid_d = 1'b1;
          err_d   = (bit_d != 4'd8);
          cs_d    = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      tx            <= 8'h00;
      rx            <= 8'h00;
      bit_cnt       <= 4'd0;
      arm_cnt       <= '0;
      sclk_q        <= 1'b0;
      o_ready       <= 1'b1;
      o_data        <= 8'h00;
      o_valid       <= 1'b0;
      o_err         <= 1'b0;
      o_div_start_n <= 1'b1;
      o_mosi        <= 1'b0;
      o_cs_n        <= 1'b1;
    end else begin
      state         <= state_d;
      tx            <= tx_d;
      rx            <= rx_d;
      bit_cnt       <= bit_d;
      arm_cnt       <= arm_d;
      sclk_q        <= i_sclk;
      o_ready       <= ready_d;
      o_data        <= data_d;
      o_valid       <= valid_d;
      o_err         <= err_d;
      o_div_start_n <= dstart_d;
      o_mosi        <= mosi_d;
      o_cs_n        <= cs_d;
    end
  end

endmodule

// File: doc/spi_byte_shifter.md
Name: spi_byte_shifter

Overview:
- Full-duplex SPI mode-0 byte engine. Sits directly downstream of clock_divider and consumes its o_clk/o_ready pair.
- Per transfer: asserts chip select, kicks the divider via its active-low start, and shifts one byte out on MOSI while capturing one byte from MISO.
- Presents the received byte with a one-cycle valid pulse.
- All logic runs in the i_clk domain. The divider clock is edge-detected, never used as a clock.

Parameters:
- MSB_FIRST, 1, 1 = bit 7 shifted first on both MOSI and MISO; 0 = bit 0 first.
- ARM_TIMEOUT, 16, max i_clk cycles to wait for the divider to drop i_div_ready after start before aborting.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_data  input  8  byte to transmit; sampled on the start cycle.
- i_start_n  input  1  active-low transfer request; sampled only in IDLE.
- o_ready  output  1  high in IDLE, able to accept a start.
- o_data  output  8  last received byte; holds until next completion.
- o_valid  output  1  one-cycle pulse when o_data updates.
- o_err  output  1  one-cycle pulse on abort or short transfer.
- o_div_start_n  output  1  to clock_divider i_start_n.
- i_div_ready  input  1  from clock_divider o_ready.
- i_sclk  input  1  from clock_divider o_clk; idles low; 8 periods per run.
- i_miso  input  1  serial data in.
- o_mosi  output  1  serial data out.
- o_cs_n  output  1  active-low chip select.

Behaviour:
- Outputs are registered.
- Reset values: state IDLE, o_ready=1, o_data=0, o_valid=0, o_err=0, o_div_start_n=1, o_mosi=0, o_cs_n=1, bit counter=0.
- Reset mid-transfer returns to these values on the next posedge. The divider is not explicitly stopped.

States:
- IDLE:
  - i_start_n=0 sampled at posedge -> latch i_data into the tx shift register and clear rx.
  - Next cycle: o_ready=0, o_cs_n=0, o_div_start_n=0, o_mosi = first bit (i_data[7] if MSB_FIRST), arm counter=0. Go to ARM.
  - i_start_n is ignored in every other state.
- ARM:
  - Hold o_div_start_n=0 until i_div_ready is sampled 0. Then o_div_start_n=1, go to SHIFT.
  - If the arm counter reaches ARM_TIMEOUT with i_div_ready still 1: o_err pulse, o_cs_n=1, o_div_start_n=1, go to IDLE. o_valid stays 0 and o_data is unchanged.
- SHIFT:
  - sclk_q = i_sclk delayed one i_clk cycle; sclk_q resets to 0.
  - Rising edge (i_sclk=1, sclk_q=0): shift i_miso into rx, bit counter +1.
  - Falling edge (i_sclk=0, sclk_q=1) with counter<8: o_mosi <= next tx bit.
  - The eighth falling edge leaves o_mosi unchanged.
  - Completion: when i_div_ready is sampled 1:
    - o_data <= rx, o_valid=1 for one cycle, o_cs_n=1.
    - If counter != 8, o_err=1 in the same cycle (data is still presented).
    - Go to IDLE; o_ready=1 the following cycle.
- Minimum supported divisor is 2 (i_sclk high 1 cycle, low 1 cycle). Edge detection must not miss an edge at divisor 2.
- A rising edge and completion in the same cycle: the shift is applied before o_data is loaded.
- o_mosi is stable for at least one i_clk cycle before every i_sclk rising edge.
- Back-to-back: a start asserted in the first IDLE cycle after completion is accepted. No bubble beyond that one IDLE cycle.

Test Plan:
- Reset: hold i_rst_n=0 for 16 cycles, release -> o_ready=1, o_cs_n=1, o_div_start_n=1, o_valid=0, o_err=0.
- Divider at divisor 4; i_data=8'hA5; loopback i_mosi->i_miso -> single o_valid pulse, o_data=8'hA5, o_err=0. o_cs_n is low for the whole transfer. MOSI sampled at each i_sclk rise reads 1,0,1,0,0,1,0,1.
- Divisor 2; i_data=8'h3C; MISO driven from the slave model with 8'hC3 -> o_data=8'hC3, no error. Exactly 8 rising edges are counted.
- MSB_FIRST=0, divisor 100; i_data=8'h01 -> first MOSI bit at the first rise is 1, remaining 7 are 0. Loopback gives o_data=8'h01.
- Divider model never drops ready -> o_err pulse exactly ARM_TIMEOUT (16) cycles after o_div_start_n falls; o_valid=0; o_data unchanged; back in IDLE.
- Assert i_rst_n=0 after the 3rd rising edge -> next posedge shows all reset values. A new transfer of 8'h5A then completes correctly. Also: i_start_n held low through a whole transfer -> exactly one transfer per IDLE entry.
